// File: rtl/dut_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the dutMem port.
// slave = arbiter view, master = requester/memory environment view.
interface dut_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  req0;
  logic                  req1;
  logic                  wr_rd0;
  logic                  wr_rd1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  done0;
  logic                  done1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  err0;
  logic                  err1;
  logic                  mem_sel;
  logic                  mem_wr_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  req0, req1, wr_rd0, wr_rd1, addr0, addr1, wdata0, wdata1,
    output done0, done1, rdata0, rdata1, err0, err1,
    output mem_sel, mem_wr_rd, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output req0, req1, wr_rd0, wr_rd1, addr0, addr1, wdata0, wdata1,
    input  done0, done1, rdata0, rdata1, err0, err1,
    input  mem_sel, mem_wr_rd, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dut_mem_arbiter.sv
// Two-requester round-robin arbiter sharing one dutMem port.
// Optional BUSY timeout enabled by defining DUT_MEM_ARB_TIMEOUT_EN.
module dut_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
`ifdef DUT_MEM_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input logic              clk,
  input logic              reset_n,
  dut_mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nx;
  logic                  last_grant, last_grant_nx;
  logic                  owner, owner_nx;
  logic                  grant;
  logic                  sel, sel_nx;
  logic                  wr_rd, wr_rd_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [DATA_WIDTH-1:0] wdata, wdata_nx;
  logic                  done0, done0_nx;
  logic                  done1, done1_nx;
  logic [DATA_WIDTH-1:0] rdata0, rdata0_nx;
  logic [DATA_WIDTH-1:0] rdata1, rdata1_nx;

`ifdef DUT_MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  err0, err0_nx;
  logic                  err1, err1_nx;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      sel        <= 1'b0;
      wr_rd      <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
`ifdef DUT_MEM_ARB_TIMEOUT_EN
      cnt        <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      owner      <= owner_nx;
      sel        <= sel_nx;
      wr_rd      <= wr_rd_nx;
      addr       <= addr_nx;
      wdata      <= wdata_nx;
      done0      <= done0_nx;
      done1      <= done1_nx;
      rdata0     <= rdata0_nx;
      rdata1     <= rdata1_nx;
`ifdef DUT_MEM_ARB_TIMEOUT_EN
      cnt        <= cnt_nx;
      err0       <= err0_nx;
      err1       <= err1_nx;
`endif
    end
  end

  // Arbitration, command latch and completion
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    owner_nx      = owner;
    grant         = 1'b0;
    sel_nx        = sel;
    wr_rd_nx      = wr_rd;
    addr_nx       = addr;
    wdata_nx      = wdata;
    done0_nx      = 1'b0;
    done1_nx      = 1'b0;
    rdata0_nx     = rdata0;
    rdata1_nx     = rdata1;
`ifdef DUT_MEM_ARB_TIMEOUT_EN
    cnt_nx        = cnt;
    err0_nx       = 1'b0;
    err1_nx       = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Tie goes to the requester not served last
          grant     = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
          owner_nx  = grant;
          sel_nx    = 1'b1;
          wr_rd_nx  = grant ? bus.wr_rd1 : bus.wr_rd0;
          addr_nx   = grant ? bus.addr1  : bus.addr0;
          wdata_nx  = grant ? bus.wdata1 : bus.wdata0;
          state_nx  = BUSY;
`ifdef DUT_MEM_ARB_TIMEOUT_EN
          cnt_nx    = '0;
`endif
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          sel_nx        = 1'b0;
          last_grant_nx = owner;
          state_nx      = IDLE;
          if (owner) begin
            done1_nx = 1'b1;
            if (!wr_rd) rdata1_nx = bus.mem_rdata;
          end else begin
            done0_nx = 1'b1;
            if (!wr_rd) rdata0_nx = bus.mem_rdata;
          end
        end
`ifdef DUT_MEM_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          sel_nx        = 1'b0;
          last_grant_nx = owner;
          state_nx      = IDLE;
          if (owner) begin
            done1_nx = 1'b1;
            err1_nx  = 1'b1;
          end else begin
            done0_nx = 1'b1;
            err0_nx  = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.mem_sel   = sel;
  assign bus.mem_wr_rd = wr_rd;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.done0     = done0;
  assign bus.done1     = done1;
  assign bus.rdata0    = rdata0;
  assign bus.rdata1    = rdata1;
`ifdef DUT_MEM_ARB_TIMEOUT_EN
  assign bus.err0      = err0;
  assign bus.err1      = err1;
`else
  assign bus.err0      = 1'b0;
  assign bus.err1      = 1'b0;
`endif

endmodule
